// File: rtl/cascade_link_tx.sv
// cascade_link_tx: frames a valid/ready payload stream as SOF, data/EOF and XOR-checksum beats
// onto the cascade PHY data and command lanes once training reports link-up.
`default_nettype none

module cascade_link_tx #(
  parameter int DAT_OUT    = 8,
  parameter int CMD_OUT    = 2,
  parameter int SER_FACTOR = 4,
  parameter int MAX_LEN    = 256,
  parameter int SEQ_W      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_link_up,
  input  logic                          i_s_valid,
  input  logic [DAT_OUT*SER_FACTOR-1:0] i_s_data,
  input  logic                          i_s_last,
  output logic                          o_s_ready,
  output logic [DAT_OUT*SER_FACTOR-1:0] o_tx_data,
  output logic [CMD_OUT*SER_FACTOR-1:0] o_tx_cmd,
  output logic [15:0]                   o_frame_cnt,
  output logic                          o_err_len
);

  localparam int DW    = DAT_OUT * SER_FACTOR;
  localparam int CW    = CMD_OUT * SER_FACTOR;
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  localparam logic [SER_FACTOR-1:0] CODE_IDLE = SER_FACTOR'(4'h0);
  localparam logic [SER_FACTOR-1:0] CODE_SOF  = SER_FACTOR'(4'h9);
  localparam logic [SER_FACTOR-1:0] CODE_DAT  = SER_FACTOR'(4'h5);
  localparam logic [SER_FACTOR-1:0] CODE_EOF  = SER_FACTOR'(4'hA);
  localparam logic [SER_FACTOR-1:0] CODE_CHK  = SER_FACTOR'(4'h6);

  typedef enum logic [2:0] {
    ST_DOWN = 3'd0,
    ST_IDLE = 3'd1,
    ST_SOF  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DROP = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [DW-1:0]      data_nxt;
  logic [SER_FACTOR-1:0] code_nxt;
  logic [CW-1:0]      cmd_nxt;
  logic               err_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]      chk, chk_nxt;
  logic               drop, drop_nxt;
  logic [SEQ_W-1:0]   seq, seq_nxt;
  logic [15:0]        frame_cnt_nxt;
  logic               accept;

  assign o_s_ready = i_link_up & ((state == ST_DATA) | (state == ST_DROP));
  assign accept    = i_s_valid & o_s_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_DOWN;
      o_tx_data   <= '0;
      o_tx_cmd    <= '0;
      o_err_len   <= 1'b0;
      o_frame_cnt <= '0;
      cnt         <= '0;
      chk         <= '0;
      drop        <= 1'b0;
      seq         <= '0;
    end else begin
      state       <= state_nxt;
      o_tx_data   <= data_nxt;
      o_tx_cmd    <= cmd_nxt;
      o_err_len   <= err_nxt;
      o_frame_cnt <= frame_cnt_nxt;
      cnt         <= cnt_nxt;
      chk         <= chk_nxt;
      drop        <= drop_nxt;
      seq         <= seq_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    data_nxt      = '0;
    code_nxt      = CODE_IDLE;
    err_nxt       = 1'b0;
    cnt_nxt       = cnt;
    chk_nxt       = chk;
    drop_nxt      = drop;
    seq_nxt       = seq;
    frame_cnt_nxt = o_frame_cnt;

    // Losing the link aborts any frame; sequence and frame counters survive.
    if (state != ST_DOWN && !i_link_up) begin
      state_nxt = ST_DOWN;
      cnt_nxt   = '0;
      chk_nxt   = '0;
      drop_nxt  = 1'b0;
    end else begin
      case (state)
        ST_DOWN: if (i_link_up) state_nxt = ST_IDLE;
        ST_IDLE: if (i_s_valid) state_nxt = ST_SOF;
        ST_SOF: begin
          code_nxt  = CODE_SOF;
          data_nxt  = DW'(seq);
          chk_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (accept) begin
            data_nxt = i_s_data;
            chk_nxt  = chk ^ i_s_data;
            cnt_nxt  = cnt + CNT_W'(1);
            if (i_s_last) begin
              code_nxt  = CODE_EOF;
              state_nxt = ST_CHK;
            end else if (cnt == CNT_W'(MAX_LEN - 1)) begin
              code_nxt  = CODE_EOF;
              err_nxt   = 1'b1;
              drop_nxt  = 1'b1;
              state_nxt = ST_CHK;
            end else begin
              code_nxt = CODE_DAT;
            end
          end
        end
        ST_CHK: begin
          code_nxt      = CODE_CHK;
          data_nxt      = chk;
          seq_nxt       = seq + SEQ_W'(1);
          frame_cnt_nxt = o_frame_cnt + 16'd1;
          state_nxt     = drop ? ST_DROP : ST_IDLE;
        end
        ST_DROP: begin
          if (accept && i_s_last) begin
            drop_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_DOWN;
      endcase
    end

    // Each command slot bit is replicated across every command lane.
    cmd_nxt = '0;
    for (int k = 0; k < SER_FACTOR; k++) begin
      for (int l = 0; l < CMD_OUT; l++) begin
        cmd_nxt[k*CMD_OUT+l] = code_nxt[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cascade_link_tx.sv
// tb_cascade_link_tx: directed-vector bench for cascade_link_tx (MAX_LEN=4 so truncation is reachable).
`default_nettype none

module tb_cascade_link_tx;

  localparam logic [7:0] C_IDLE = 8'h00;
  localparam logic [7:0] C_SOF  = 8'hC3;
  localparam logic [7:0] C_DAT  = 8'h33;
  localparam logic [7:0] C_EOF  = 8'hCC;
  localparam logic [7:0] C_CHK  = 8'h3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        link_up = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] tx_data;
  logic [7:0]  tx_cmd;
  logic [15:0] frame_cnt;
  logic        err_len;

  int vectors = 0;
  int errors  = 0;

  cascade_link_tx #(
    .DAT_OUT(8), .CMD_OUT(2), .SER_FACTOR(4), .MAX_LEN(4), .SEQ_W(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up), .i_s_valid(s_valid),
    .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(s_ready),
    .o_tx_data(tx_data), .o_tx_cmd(tx_cmd), .o_frame_cnt(frame_cnt), .o_err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if (tx_data !== 32'd0 || tx_cmd !== C_IDLE || s_ready !== 1'b0 || frame_cnt !== 16'd0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h cmd=%h rdy=%b fc=%0d err=%b want all zero", tx_data, tx_cmd, s_ready, frame_cnt, err_len);
    end
    @(negedge clk);
    rst = 1'b0;
    link_up = 1'b1;
    cyc();
  endtask

  task automatic test_frame4();
    s_valid = 1'b1; s_data = 32'd1; s_last = 1'b0;
    cyc();
    vectors++;
    if (tx_cmd !== C_IDLE || s_ready !== 1'b0) begin
      errors++; $display("FAIL f4_idle: cmd=%h rdy=%b want %h 0", tx_cmd, s_ready, C_IDLE);
    end
    cyc();
    vectors++;
    if (tx_cmd !== C_SOF || tx_data !== 32'd0) begin
      errors++; $display("FAIL f4_sof: cmd=%h data=%h want %h 0", tx_cmd, tx_data, C_SOF);
    end
    for (int i = 1; i <= 4; i++) begin
      s_data = i; s_last = (i == 4);
      vectors++;
      if (s_ready !== 1'b1) begin
        errors++; $display("FAIL f4_ready%0d: got %b want 1", i, s_ready);
      end
      cyc();
      vectors++;
      if (tx_cmd !== ((i == 4) ? C_EOF : C_DAT) || tx_data !== 32'(i)) begin
        errors++; $display("FAIL f4_beat%0d: cmd=%h data=%h want %h %h", i, tx_cmd, tx_data, (i == 4) ? C_EOF : C_DAT, i);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    cyc();
    vectors++;
    if (tx_cmd !== C_CHK || tx_data !== 32'd4 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL f4_chk: cmd=%h data=%h fc=%0d want %h 4 1", tx_cmd, tx_data, frame_cnt, C_CHK);
    end
    cyc();
    vectors++;
    if (tx_cmd !== C_IDLE || tx_data !== 32'd0) begin
      errors++; $display("FAIL f4_post: cmd=%h data=%h want idle 0", tx_cmd, tx_data);
    end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_last = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cyc();
      vectors++;
      if (tx_cmd !== C_IDLE) begin
        errors++; $display("FAIL b2b_gap%0d: cmd=%h want idle", f, tx_cmd);
      end
      cyc();
      vectors++;
      if (tx_cmd !== C_SOF || tx_data !== 32'(1 + f)) begin
        errors++; $display("FAIL b2b_sof%0d: cmd=%h data=%h want %h %h", f, tx_cmd, tx_data, C_SOF, 1 + f);
      end
      cyc();
      vectors++;
      if (tx_cmd !== C_EOF || tx_data !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL b2b_eof%0d: cmd=%h data=%h", f, tx_cmd, tx_data);
      end
      if (f == 1) s_valid = 1'b0;
      cyc();
      vectors++;
      if (tx_cmd !== C_CHK || tx_data !== 32'hA5A5A5A5 || frame_cnt !== 16'(2 + f)) begin
        errors++; $display("FAIL b2b_chk%0d: cmd=%h data=%h fc=%0d want %h a5a5a5a5 %0d", f, tx_cmd, tx_data, frame_cnt, C_CHK, 2 + f);
      end
    end
    s_last = 1'b0;
    cyc();
  endtask

  task automatic test_stall();
    s_valid = 1'b1; s_data = 32'h11; s_last = 1'b0;
    cyc();
    cyc();
    vectors++;
    if (tx_cmd !== C_SOF || tx_data !== 32'd3) begin
      errors++; $display("FAIL st_sof: cmd=%h data=%h want %h 3", tx_cmd, tx_data, C_SOF);
    end
    cyc();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (tx_cmd !== C_IDLE || tx_data !== 32'd0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL st_fill%0d: cmd=%h data=%h rdy=%b want idle 0 1", i, tx_cmd, tx_data, s_ready);
      end
    end
    s_valid = 1'b1; s_data = 32'h22;
    cyc();
    s_data = 32'h44; s_last = 1'b1;
    cyc();
    vectors++;
    if (tx_cmd !== C_EOF || tx_data !== 32'h44) begin
      errors++; $display("FAIL st_eof: cmd=%h data=%h want %h 44", tx_cmd, tx_data, C_EOF);
    end
    s_valid = 1'b0; s_last = 1'b0;
    cyc();
    vectors++;
    if (tx_cmd !== C_CHK || tx_data !== 32'h77 || frame_cnt !== 16'd4) begin
      errors++; $display("FAIL st_chk: cmd=%h data=%h fc=%0d want %h 77 4", tx_cmd, tx_data, frame_cnt, C_CHK);
    end
    cyc();
  endtask

  task automatic test_truncate();
    s_valid = 1'b1; s_data = 32'h1; s_last = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      s_data = 32'(1) << i;
      cyc();
      vectors++;
      if (tx_cmd !== ((i == 3) ? C_EOF : C_DAT) || err_len !== (i == 3)) begin
        errors++; $display("FAIL tr_beat%0d: cmd=%h err=%b want %h %b", i + 1, tx_cmd, err_len, (i == 3) ? C_EOF : C_DAT, i == 3);
      end
    end
    s_data = 32'h10;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL tr_chk_rdy: got %b want 0", s_ready);
    end
    cyc();
    vectors++;
    if (tx_cmd !== C_CHK || tx_data !== 32'hF || err_len !== 1'b0 || frame_cnt !== 16'd5) begin
      errors++; $display("FAIL tr_chk: cmd=%h data=%h err=%b fc=%0d want %h f 0 5", tx_cmd, tx_data, err_len, frame_cnt, C_CHK);
    end
    for (int i = 0; i < 2; i++) begin
      s_last = (i == 1); s_data = (i == 1) ? 32'h20 : 32'h10;
      vectors++;
      if (s_ready !== 1'b1) begin
        errors++; $display("FAIL tr_drop_rdy%0d: got %b want 1", i, s_ready);
      end
      cyc();
      vectors++;
      if (tx_cmd !== C_IDLE || tx_data !== 32'd0) begin
        errors++; $display("FAIL tr_drop%0d: cmd=%h data=%h want idle 0", i, tx_cmd, tx_data);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    cyc();
    vectors++;
    if (tx_cmd !== C_IDLE || s_ready !== 1'b0) begin
      errors++; $display("FAIL tr_after: cmd=%h rdy=%b want idle 0", tx_cmd, s_ready);
    end
  endtask

  task automatic test_link_drop();
    s_valid = 1'b1; s_data = 32'hAA; s_last = 1'b0;
    cyc();
    cyc();
    vectors++;
    if (tx_cmd !== C_SOF || tx_data !== 32'd5) begin
      errors++; $display("FAIL ld_sof: cmd=%h data=%h want %h 5", tx_cmd, tx_data, C_SOF);
    end
    cyc();
    s_data = 32'hBB; s_last = 1'b1; link_up = 1'b0;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL ld_gate: rdy=%b want 0", s_ready);
    end
    cyc();
    vectors++;
    if (tx_cmd !== C_IDLE || tx_data !== 32'd0 || frame_cnt !== 16'd5 || s_ready !== 1'b0) begin
      errors++; $display("FAIL ld_down: cmd=%h data=%h fc=%0d rdy=%b want idle 0 5 0", tx_cmd, tx_data, frame_cnt, s_ready);
    end
    link_up = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    cyc();
    s_valid = 1'b1; s_data = 32'hCC; s_last = 1'b1;
    cyc();
    cyc();
    vectors++;
    if (tx_cmd !== C_SOF || tx_data !== 32'd5) begin
      errors++; $display("FAIL ld_resof: cmd=%h data=%h want %h 5", tx_cmd, tx_data, C_SOF);
    end
    cyc();
    s_valid = 1'b0; s_last = 1'b0;
    cyc();
    vectors++;
    if (tx_cmd !== C_CHK || tx_data !== 32'hCC || frame_cnt !== 16'd6) begin
      errors++; $display("FAIL ld_chk: cmd=%h data=%h fc=%0d want %h cc 6", tx_cmd, tx_data, frame_cnt, C_CHK);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1; s_data = 32'h77; s_last = 1'b0;
    cyc();
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (tx_data !== 32'd0 || tx_cmd !== C_IDLE || frame_cnt !== 16'd0 || s_ready !== 1'b0 || err_len !== 1'b0) begin
      errors++; $display("FAIL arst: data=%h cmd=%h fc=%0d rdy=%b err=%b want zero", tx_data, tx_cmd, frame_cnt, s_ready, err_len);
    end
    @(negedge clk);
    rst = 1'b0; s_data = 32'h55; s_last = 1'b1;
    cyc();
    cyc();
    cyc();
    vectors++;
    if (tx_cmd !== C_SOF || tx_data !== 32'd0) begin
      errors++; $display("FAIL arst_seq: cmd=%h data=%h want %h 0", tx_cmd, tx_data, C_SOF);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame4();
    test_back_to_back();
    test_stall();
    test_truncate();
    test_link_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
